// File: rtl/seg_hex_scan.sv
// seg_hex_scan: time-multiplexed driver for an 8-digit common-anode hex display.
// A 32-bit word is shown one nibble per digit (digit 7 leftmost). Loads land in
// a pending register and are promoted to the displayed (active) register only
// at the digit-7 -> digit-0 wrap, so a frame never mixes old and new data.
//
// Load strobe: ld is a single-cycle qualifier with no back-pressure. Every
// cycle with ld=1 captures {din, lz_en, blink}; the last one before (or on)
// a frame boundary is the one that gets displayed in the following frame.
module seg_hex_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] din,
  input  logic        ld,
  input  logic        lz_en,
  input  logic [7:0]  blink,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // scan position
  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic          presc_term;
  logic          boundary;

  // blink timing; phase_on=1 means blinking digits are currently visible
  logic [BW-1:0] blink_cnt;
  logic          phase_on;

  // pending and active copies of the display request
  logic [31:0]   pend_din;
  logic          pend_lz;
  logic [7:0]    pend_blink;
  logic [31:0]   act_din;
  logic          act_lz;
  logic [7:0]    act_blink;

  // delays the boundary by one cycle so frame_done lines up with the
  // first (blank) output cycle of digit 0
  logic          wrap_q;

  // combinational view of the current slot
  logic [3:0]    nib;
  logic          lz_blank;
  logic          blink_blank;
  logic          slot_blank;
  logic          blank;

  assign presc_term = (presc == PW'(SCAN_DIV - 1));
  assign boundary   = presc_term && (idx == 3'd7);
  assign dp         = 1'b1;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // prescaler and digit index; the digit index wraps 7->0 at the frame boundary
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc <= '0;
      idx   <= 3'd0;
    end else if (presc_term) begin
      presc <= '0;
      idx   <= idx + 3'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // pending register follows every load strobe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_din   <= 32'd0;
      pend_lz    <= 1'b0;
      pend_blink <= 8'd0;
    end else if (ld) begin
      pend_din   <= din;
      pend_lz    <= lz_en;
      pend_blink <= blink;
    end
  end

  // active register is promoted at the boundary; a load in that same cycle bypasses pending
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_din   <= 32'd0;
      act_lz    <= 1'b0;
      act_blink <= 8'd0;
    end else if (boundary) begin
      act_din   <= ld ? din   : pend_din;
      act_lz    <= ld ? lz_en : pend_lz;
      act_blink <= ld ? blink : pend_blink;
    end
  end

  // blink phase toggles every BLINK_FRAMES frame boundaries
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (boundary) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        phase_on  <= ~phase_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // blanking decision and segment pattern for the digit currently selected
  always_comb begin
    nib         = act_din[{idx, 2'b00} +: 4];
    slot_blank  = (presc < PW'(BLANK_CYC));
    lz_blank    = act_lz && (idx != 3'd0) && ((act_din >> {idx, 2'b00}) == 32'd0);
    blink_blank = act_blink[idx] && !phase_on;
    blank       = slot_blank || lz_blank || blink_blank;
  end

  // registered display outputs, one cycle behind the scan counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      an         <= 8'hFF;
      seg        <= 7'h7F;
      wrap_q     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      an         <= blank ? 8'hFF : ~(8'd1 << idx);
      seg        <= blank ? 7'h7F : hex_decode(nib);
      wrap_q     <= boundary;
      frame_done <= wrap_q;
    end
  end

endmodule

// File: tb/tb_seg_hex_scan.sv
// tb_seg_hex_scan: drives load requests into seg_hex_scan and checks every
// output cycle against a frame-level reference model through an expected queue.
module tb_seg_hex_scan;

  localparam int SD    = 4;
  localparam int BC    = 1;
  localparam int BF    = 2;
  localparam int FRAME = 8 * SD;

  logic        clk;
  logic        rstn;
  logic [31:0] din;
  logic        ld;
  logic        lz_en;
  logic [7:0]  blink;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  seg_hex_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rstn(rstn), .din(din), .ld(ld), .lz_en(lz_en), .blink(blink),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] exp_q[$];
  bit model_on = 0;
  bit mon_on   = 0;

  // reference model: whole-frame view of the request history
  logic [6:0]  dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          m;          // clock edges since reset release
  logic [31:0] m_pend_din, m_act_din;
  logic        m_pend_lz,  m_act_lz;
  logic [7:0]  m_pend_bl,  m_act_bl;

  task automatic model_reset();
    m = 0;
    m_pend_din = 0; m_act_din = 0;
    m_pend_lz = 0;  m_act_lz = 0;
    m_pend_bl = 0;  m_act_bl = 0;
  endtask

  always @(posedge clk) begin
    if (model_on) begin
      int pos, d, sc, f;
      bit ph_on, blank, fd;
      logic [31:0] upper;
      logic [7:0]  e_an;
      logic [6:0]  e_seg;
      pos   = m % FRAME;
      d     = pos / SD;
      sc    = pos % SD;
      f     = m / FRAME;
      ph_on = ((f / BF) % 2) == 0;
      upper = m_act_din >> (4 * d);
      blank = (sc < BC) || (m_act_lz && d != 0 && upper == 0) || (m_act_bl[d] && !ph_on);
      fd    = (pos == 0) && (m > 0);
      e_an  = blank ? 8'hFF : (8'hFF ^ (8'h01 << d));
      e_seg = blank ? 7'h7F : dec_tab[upper[3:0]];
      exp_q.push_back({e_an, e_seg, 1'b1, fd});
      if (ld) begin
        m_pend_din = din; m_pend_lz = lz_en; m_pend_bl = blink;
      end
      m = m + 1;
      if (m % FRAME == 0) begin
        m_act_din = m_pend_din; m_act_lz = m_pend_lz; m_act_bl = m_pend_bl;
      end
    end
  end

  // monitor: one output word per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_on && exp_q.size() > 0) begin
      logic [16:0] exp_v, got;
      exp_v = exp_q.pop_front();
      got   = {an, seg, dp, frame_done};
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL scan t=%0t got an=%h seg=%h dp=%b fd=%b want an=%h seg=%h dp=%b fd=%b",
                 $time, got[16:9], got[8:2], got[1], got[0],
                 exp_v[16:9], exp_v[8:2], exp_v[1], exp_v[0]);
      end
    end
  end

  // driver tasks
  task automatic drive(input bit l, input logic [31:0] d, input bit lz, input logic [7:0] bl);
    @(negedge clk);
    ld = l; din = d; lz_en = lz; blink = bl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom, $urandom_range(0, 1), 8'($urandom));
  endtask

  // load exactly when the model's frame position is p (edge count mod frame)
  task automatic load_at(input int p, input logic [31:0] d, input bit lz, input logic [7:0] bl);
    int k;
    k = 0;
    @(negedge clk);
    ld = 1'b0;
    while ((m % FRAME) != p && k < 2 * FRAME) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2 * FRAME) begin
      n_cmp++; n_bad++;
      $display("FAIL align got pos=%0d want pos=%0d", m % FRAME, p);
    end
    ld = 1'b1; din = d; lz_en = lz; blink = bl;
  endtask

  task automatic check_reset(input string name);
    n_cmp++;
    if ({an, seg, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL %s got an=%h seg=%h dp=%b fd=%b want an=ff seg=7f dp=1 fd=0",
               name, an, seg, dp, frame_done);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    exp_q.delete();
    model_reset();
    rstn = 1'b1;
    model_on = 1;
    mon_on = 1;
  endtask

  initial begin
    rstn = 1'b0; ld = 1'b0; din = 32'd0; lz_en = 1'b0; blink = 8'd0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset("reset_hold");
    end
    release_reset();

    // two frames of reset content, then the plain hex pattern
    idle(2 * FRAME);
    load_at(5, 32'h0123_ABCD, 1'b0, 8'h00);
    idle(2 * FRAME + 8);

    // leading-zero blanking
    load_at(12, 32'h0000_00A0, 1'b1, 8'h00);
    idle(2 * FRAME);
    load_at(20, 32'h0000_0000, 1'b1, 8'h00);
    idle(2 * FRAME);

    // blink on digit 0
    load_at(3, 32'h0000_0005, 1'b0, 8'h01);
    idle(5 * FRAME);

    // frame coherence: two loads in one frame, then a load on the boundary cycle
    load_at(8, 32'h1111_1111, 1'b0, 8'h00);
    idle(5);
    drive(1'b1, 32'h2222_2222, 1'b0, 8'h00);
    idle(2 * FRAME);
    load_at(FRAME - 1, 32'h89AB_CDEF, 1'b0, 8'h00);
    idle(FRAME + 4);

    // ld held high with changing data
    for (int i = 0; i < 3 * FRAME; i++) drive(1'b1, $urandom, 1'b0, 8'h00);

    // random traffic
    for (int i = 0; i < 20 * FRAME; i++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 1)) r = r >> (4 * $urandom_range(0, 7));
      drive($urandom_range(0, 15) == 0, r, $urandom_range(0, 1), 8'($urandom));
    end
    idle(FRAME);

    // reset while digit 4 is lit (output reflects position 18)
    load_at(19, 32'h4444_4444, 1'b0, 8'h00);
    ld = 1'b0;
    mon_on = 0;
    model_on = 0;
    #2 rstn = 1'b0;
    #1 check_reset("reset_async");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_reset("reset_mid_hold");
    end
    release_reset();
    idle(2 * FRAME + 3);

    @(negedge clk);
    mon_on = 0;
    model_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
